// File: rtl/hardwired_control_unit.sv
// Hardwired T-step control sequencer for the 32-bit RISC datapath.
// Adds a bounded memory-wait handshake, an illegal-opcode trap and run/halt control.
module hardwired_control_unit #(
   parameter logic [4:0] ALU_ADD     = 5'd2,
   parameter logic [4:0] ALU_INC     = 5'd12,
   parameter int         MEM_TIMEOUT = 16,
   parameter logic [4:0] BR_OP       = 5'd15
) (
   input  logic        clk,
   input  logic        clr,
   input  logic        run_in,
   input  logic [31:0] ir,
   input  logic        con_ff,
   input  logic        mem_ready,
   output logic        PCout,
   output logic        Zlowout,
   output logic        Zhighout,
   output logic        MDRout,
   output logic        InPortout,
   output logic        PCin,
   output logic        IRin,
   output logic        MARin,
   output logic        MDRin,
   output logic        Yin,
   output logic        Zin,
   output logic        CONin,
   output logic        OutportIn,
   output logic        Gra,
   output logic        Grb,
   output logic        Grc,
   output logic        Rin,
   output logic        Rout,
   output logic        BAout,
   output logic        Cout,
   output logic [4:0]  ALU_Control,
   output logic        Read,
   output logic        Write,
   output logic        run,
   output logic        halted,
   output logic        mem_err,
   output logic        illegal,
   output logic [3:0]  step
);

   typedef enum logic [3:0] {
      S_IDLE, S_T0, S_T1, S_T2, S_T3, S_T4, S_T5, S_T6, S_T7, S_HALT
   } state_t;

   // The counter only ever holds 0 .. MEM_TIMEOUT-1; the last value triggers the trap.
   localparam int CW = (MEM_TIMEOUT < 2) ? 1 : $clog2(MEM_TIMEOUT);
   localparam logic [CW-1:0] CNT_LAST = CW'(MEM_TIMEOUT - 1);

   state_t         state_reg, state_next;
   logic [CW-1:0]  cnt_reg;
   logic           mem_err_reg, illegal_reg;
   logic           in_wait, timeout, illegal_set;

   logic [4:0] op;
   logic       is_ld, is_ldi, is_st, is_br, is_alur, is_alui;
   logic       is_in, is_out, is_nop, is_halt, is_legal;
   logic       first_cycle, at_limit;
   logic       unused_ir;

   assign op        = ir[31:27];
   assign unused_ir = ^ir[26:0];

   // Branch decode wins if BR_OP is ever parametrised onto another opcode.
   assign is_br    = (op == BR_OP);
   assign is_ld    = !is_br && (op == 5'd0);
   assign is_ldi   = !is_br && (op == 5'd1);
   assign is_st    = !is_br && (op == 5'd2);
   assign is_alur  = !is_br && (op >= 5'd3) && (op <= 5'd11);
   assign is_alui  = !is_br && (op >= 5'd12) && (op <= 5'd14);
   assign is_in    = !is_br && (op == 5'd16);
   assign is_out   = !is_br && (op == 5'd17);
   assign is_nop   = !is_br && (op == 5'd26);
   assign is_halt  = !is_br && (op == 5'd27);
   assign is_legal = is_ld | is_ldi | is_st | is_br | is_alur | is_alui |
                     is_in | is_out | is_nop | is_halt;

   assign first_cycle = (cnt_reg == '0);
   assign at_limit    = (cnt_reg == CNT_LAST);

   always_ff @(posedge clk) begin
      if (clr) begin
         state_reg   <= S_IDLE;
         cnt_reg     <= '0;
         mem_err_reg <= 1'b0;
         illegal_reg <= 1'b0;
      end else begin
         state_reg   <= state_next;
         cnt_reg     <= (in_wait && !mem_ready && !timeout) ? cnt_reg + CW'(1) : '0;
         mem_err_reg <= mem_err_reg | timeout;
         illegal_reg <= illegal_reg | illegal_set;
      end
   end

   always_comb begin
      state_next  = state_reg;
      in_wait     = 1'b0;
      timeout     = 1'b0;
      illegal_set = 1'b0;
      PCout = 1'b0; Zlowout = 1'b0; Zhighout = 1'b0; MDRout = 1'b0; InPortout = 1'b0;
      PCin = 1'b0; IRin = 1'b0; MARin = 1'b0; MDRin = 1'b0; Yin = 1'b0; Zin = 1'b0;
      CONin = 1'b0; OutportIn = 1'b0;
      Gra = 1'b0; Grb = 1'b0; Grc = 1'b0; Rin = 1'b0; Rout = 1'b0; BAout = 1'b0; Cout = 1'b0;
      ALU_Control = 5'd0;
      Read = 1'b0; Write = 1'b0;

      case (state_reg)
         S_IDLE, S_HALT: begin
            if (run_in) state_next = S_T0;
         end
         S_T0: begin
            PCout = 1'b1; MARin = 1'b1; Zin = 1'b1; ALU_Control = ALU_INC;
            state_next = S_T1;
         end
         S_T1: begin
            in_wait = 1'b1;
            Read    = 1'b1;
            MDRin   = 1'b1;
            // PC is updated once, not on every wait cycle.
            if (first_cycle) begin
               Zlowout = 1'b1; PCin = 1'b1;
            end
            if (mem_ready) state_next = S_T2;
            else if (at_limit) begin
               timeout    = 1'b1;
               state_next = S_HALT;
            end
         end
         S_T2: begin
            MDRout = 1'b1; IRin = 1'b1;
            if (is_nop) state_next = S_T0;
            else if (is_halt) state_next = S_HALT;
            else if (!is_legal) begin
               illegal_set = 1'b1;
               state_next  = S_HALT;
            end else state_next = S_T3;
         end
         S_T3: begin
            state_next = S_T4;
            if (is_ld || is_ldi || is_st) begin
               Grb = 1'b1; BAout = 1'b1; Yin = 1'b1;
            end else if (is_alur || is_alui) begin
               Grb = 1'b1; Rout = 1'b1; Yin = 1'b1;
            end else if (is_br) begin
               Gra = 1'b1; Rout = 1'b1; CONin = 1'b1;
            end else if (is_in) begin
               InPortout = 1'b1; Gra = 1'b1; Rin = 1'b1;
               state_next = S_T0;
            end else if (is_out) begin
               Gra = 1'b1; Rout = 1'b1; OutportIn = 1'b1;
               state_next = S_T0;
            end else state_next = S_T0;
         end
         S_T4: begin
            state_next = S_T5;
            if (is_ld || is_ldi || is_st) begin
               Cout = 1'b1; Zin = 1'b1; ALU_Control = ALU_ADD;
            end else if (is_alur) begin
               Grc = 1'b1; Rout = 1'b1; Zin = 1'b1; ALU_Control = op;
            end else if (is_alui) begin
               Cout = 1'b1; Zin = 1'b1; ALU_Control = op;
            end else if (is_br) begin
               PCout = 1'b1; Yin = 1'b1;
            end else state_next = S_T0;
         end
         S_T5: begin
            state_next = S_T0;
            if (is_ld || is_st) begin
               Zlowout = 1'b1; MARin = 1'b1;
               state_next = S_T6;
            end else if (is_ldi || is_alur || is_alui) begin
               Zlowout = 1'b1; Gra = 1'b1; Rin = 1'b1;
            end else if (is_br) begin
               Cout = 1'b1; Zin = 1'b1; ALU_Control = ALU_ADD;
               state_next = S_T6;
            end
         end
         S_T6: begin
            state_next = S_T0;
            if (is_ld) begin
               in_wait = 1'b1; Read = 1'b1; MDRin = 1'b1;
               if (mem_ready) state_next = S_T7;
               else if (at_limit) begin
                  timeout    = 1'b1;
                  state_next = S_HALT;
               end else state_next = S_T6;
            end else if (is_st) begin
               Gra = 1'b1; Rout = 1'b1; MDRin = 1'b1;
               state_next = S_T7;
            end else if (is_br && con_ff) begin
               Zlowout = 1'b1; PCin = 1'b1;
            end
         end
         S_T7: begin
            state_next = S_T0;
            if (is_ld) begin
               MDRout = 1'b1; Gra = 1'b1; Rin = 1'b1;
            end else if (is_st) begin
               in_wait = 1'b1; Write = 1'b1;
               if (!mem_ready) begin
                  if (at_limit) begin
                     timeout    = 1'b1;
                     state_next = S_HALT;
                  end else state_next = S_T7;
               end
            end
         end
         default: state_next = S_IDLE;
      endcase
   end

   always_comb begin
      case (state_reg)
         S_T0:    step = 4'd0;
         S_T1:    step = 4'd1;
         S_T2:    step = 4'd2;
         S_T3:    step = 4'd3;
         S_T4:    step = 4'd4;
         S_T5:    step = 4'd5;
         S_T6:    step = 4'd6;
         S_T7:    step = 4'd7;
         default: step = 4'hF;
      endcase
   end

   assign run     = (state_reg != S_IDLE) && (state_reg != S_HALT);
   assign halted  = (state_reg == S_HALT);
   assign mem_err = mem_err_reg;
   assign illegal = illegal_reg;

endmodule
